// File: rtl/ysyx_25060170_ifetch.sv
// Instruction-fetch stage: one bus read per instruction, holds the word for
// decode and pulses pc_advance once decode has accepted it.
module ysyx_25060170_ifetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  input  logic              inst_ready,
  output logic [31:0]       fetch_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic                drop_q, drop_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   inst_n;
  logic [ADDR_W-1:0]   inst_pc_n;
  logic                inst_err_n;
  logic [CNT_W-1:0]    cnt_n;

  assign mem_araddr = addr_q;

  // State, capture registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      inst        <= '0;
      inst_pc     <= '0;
      inst_err    <= 1'b0;
      fetch_cnt   <= '0;
      mem_arvalid <= 1'b0;
      mem_rready  <= 1'b0;
      inst_valid  <= 1'b0;
    end else begin
      state_q     <= state_n;
      drop_q      <= drop_n;
      addr_q      <= addr_n;
      inst        <= inst_n;
      inst_pc     <= inst_pc_n;
      inst_err    <= inst_err_n;
      fetch_cnt   <= cnt_n;
      mem_arvalid <= (state_n == S_ADDR);
      mem_rready  <= (state_n == S_DATA);
      inst_valid  <= (state_n == S_HOLD);
    end
  end

  // Next-state, capture and pc_advance logic
  always_comb begin
    state_n    = state_q;
    drop_n     = drop_q;
    addr_n     = addr_q;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    inst_err_n = inst_err;
    cnt_n      = fetch_cnt;
    pc_advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_n = pc;
        drop_n = 1'b0;
        if (pc[1:0] != 2'b00) begin
          // Misaligned: deliver a fault without touching the bus
          inst_n     = '0;
          inst_pc_n  = pc;
          inst_err_n = 1'b1;
          state_n    = S_HOLD;
        end else begin
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (flush) drop_n = 1'b1;
        if (mem_arready) state_n = S_DATA;
      end
      S_DATA: begin
        if (flush) drop_n = 1'b1;
        if (mem_rvalid) begin
          // A redirect arriving with the data also discards it
          if (drop_q || flush) begin
            state_n = S_IDLE;
          end else begin
            inst_n     = mem_rdata;
            inst_pc_n  = addr_q;
            inst_err_n = (mem_rresp != 2'b00);
            state_n    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (inst_ready) begin
          pc_advance = 1'b1;
          cnt_n      = fetch_cnt + CNT_W'(1);
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25060170_ifetch.sv
// Bench for the fetch stage: directed scenarios plus randomized fetches,
// each checked against transaction-level expectations.
module tb_ysyx_25060170_ifetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  ysyx_25060170_ifetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .mem_arvalid (mem_arvalid),
    .mem_araddr  (mem_araddr),
    .mem_arready (mem_arready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rready  (mem_rready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_err    (inst_err),
    .inst_ready  (inst_ready),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete fetch, entered and left at a negedge inside an IDLE cycle.
  // fmode: 0 none, 1 flush in first DATA stall cycle, 2 flush with ready in
  // HOLD, 3 flush in first ADDR cycle.
  task automatic fetch(input logic [31:0] addr, input int na, input int nr,
                       input int nh, input logic [1:0] resp,
                       input logic [31:0] data, input int fmode);
    int          cyc;
    logic        mis;
    logic        dropped;
    logic [31:0] exp_inst;
    logic        exp_err;
    logic        accept;
    mis      = (addr[1:0] != 2'b00);
    dropped  = 1'b0;
    exp_inst = mis ? 32'h0 : data;
    exp_err  = mis || (resp != 2'b00);
    cyc      = 1;
    pc          = addr;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    inst_ready  = 1'b0;
    flush       = 1'b0;
    chk("idle_arvalid", 64'(mem_arvalid), 64'd0);
    chk("idle_inst_valid", 64'(inst_valid), 64'd0);
    #1 chk("idle_pc_advance", 64'(pc_advance), 64'd0);
    @(negedge clk); cyc++;
    if (!mis) begin
      for (int i = 0; i <= na; i++) begin
        chk("addr_arvalid", 64'(mem_arvalid), 64'd1);
        chk("addr_araddr", 64'(mem_araddr), 64'(addr));
        mem_arready = (i == na);
        flush       = (fmode == 3) && (i == 0);
        @(negedge clk); cyc++;
      end
      mem_arready = 1'b0;
      flush       = 1'b0;
      for (int i = 0; i <= nr; i++) begin
        chk("data_rready", 64'(mem_rready), 64'd1);
        chk("data_arvalid", 64'(mem_arvalid), 64'd0);
        mem_rvalid = (i == nr);
        mem_rdata  = (i == nr) ? data : $urandom;
        mem_rresp  = resp;
        flush      = (fmode == 1) && (i == 0) && (nr > 0);
        @(negedge clk); cyc++;
      end
      mem_rvalid = 1'b0;
      mem_rresp  = 2'b00;
      flush      = 1'b0;
      dropped    = ((fmode == 1) && (nr > 0)) || (fmode == 3);
    end
    if (dropped) begin
      chk("drop_inst_valid", 64'(inst_valid), 64'd0);
      chk("drop_rready", 64'(mem_rready), 64'd0);
      chk("drop_cnt", 64'(fetch_cnt), 64'(exp_cnt));
    end else begin
      chk("hold_cycle", 64'(cyc), mis ? 64'd2 : 64'(na + nr + 4));
      chk("hold_arvalid", 64'(mem_arvalid), 64'd0);
      for (int i = 0; i <= nh; i++) begin
        chk("hold_inst_valid", 64'(inst_valid), 64'd1);
        chk("hold_inst", 64'(inst), 64'(exp_inst));
        chk("hold_inst_pc", 64'(inst_pc), 64'(addr));
        chk("hold_inst_err", 64'(inst_err), 64'(exp_err));
        inst_ready = (i == nh);
        flush      = (fmode == 2) && (i == nh);
        accept     = (i == nh) && (fmode != 2);
        #1 chk("hold_pc_advance", 64'(pc_advance), 64'(accept));
        if (accept) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
      end
      inst_ready = 1'b0;
      flush      = 1'b0;
      chk("post_inst_valid", 64'(inst_valid), 64'd0);
      chk("post_fetch_cnt", 64'(fetch_cnt), 64'(exp_cnt));
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  r;
    int          na, nr, nh, fm;
    checks      = 0;
    errors      = 0;
    exp_cnt     = 32'd0;
    rst         = 1'b0;
    pc          = 32'h0;
    flush       = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    mem_rresp   = 2'b00;
    inst_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", 64'(mem_arvalid), 64'd0);
    chk("rst_rready", 64'(mem_rready), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_inst_err", 64'(inst_err), 64'd0);
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_pc_advance", 64'(pc_advance), 64'd0);
    rst = 1'b1;

    // Basic, stalled, bus-error and misaligned fetches
    fetch(32'h8000_0000, 0, 0, 0, 2'b00, 32'h0010_0093, 0);
    fetch(32'h8000_0004, 3, 2, 4, 2'b00, 32'h1234_5678, 0);
    fetch(32'h8000_0008, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 0);
    fetch(32'h8000_0002, 0, 0, 0, 2'b00, 32'h0, 0);
    fetch(32'h8000_0003, 0, 0, 2, 2'b00, 32'h0, 0);

    // Flush during DATA, then refetch from a new pc
    fetch(32'h8000_0010, 1, 2, 0, 2'b00, 32'hAAAA_5555, 1);
    fetch(32'h8000_0200, 0, 0, 0, 2'b00, 32'h5555_AAAA, 0);
    // Flush together with ready in HOLD
    fetch(32'h8000_0020, 0, 0, 1, 2'b00, 32'h0BAD_F00D, 2);
    fetch(32'h8000_0024, 0, 0, 0, 2'b00, 32'h0000_0013, 0);
    // Flush in ADDR
    fetch(32'h8000_0030, 2, 0, 0, 2'b00, 32'hCAFE_0001, 3);

    // Reset asserted in the middle of DATA
    pc = 32'h8000_0100;
    @(negedge clk);
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_arvalid", 64'(mem_arvalid), 64'd0);
    chk("midrst_rready", 64'(mem_rready), 64'd0);
    chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_inst", 64'(inst), 64'd0);
    chk("midrst_inst_pc", 64'(inst_pc), 64'd0);
    chk("midrst_inst_err", 64'(inst_err), 64'd0);
    chk("midrst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("midrst_araddr", 64'(mem_araddr), 64'd0);
    chk("midrst_pc_advance", 64'(pc_advance), 64'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h8000_0100, 0, 1, 0, 2'b00, 32'h0000_0297, 0);

    // Randomized fetches
    for (int k = 0; k < 40; k++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d  = $urandom;
      r  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      na = $urandom_range(0, 3);
      nr = $urandom_range(0, 3);
      nh = $urandom_range(0, 3);
      fm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      if (fm == 1 && nr == 0) nr = 1;
      fetch(a, na, nr, nh, r, d, fm);
      if (fm != 0) fetch(a + 32'd64, 0, 0, 0, 2'b00, ~d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
